// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game: playback/check engine states,
// tone index type, the tone-to-button mapping table and a button encoder.
package simon_pkg;

  // Engine states: idle, tone sounding, silence between tones, grading presses
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY_ON  = 2'd1,
    S_PLAY_GAP = 2'd2,
    S_LISTEN   = 2'd3
  } seq_state_t;

  typedef logic [1:0] tone_idx_t;

  // Button / lamp pattern belonging to each tone index; the game FSM drives
  // its lamps from the same table, so tone N is always button bit N.
  localparam logic [3:0] GAME_TONES [0:3] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // Encode a button vector to a tone index. Only meaningful for one-hot input;
  // callers check one-hotness by mapping the result back through GAME_TONES.
  function automatic tone_idx_t onehot_to_idx(input logic [3:0] oh);
    tone_idx_t idx;
    if (oh[3]) begin
      idx = 2'd3;
    end else if (oh[2]) begin
      idx = 2'd2;
    end else if (oh[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the source of new tones.
module simon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_lfsr = r_lfsr;

  // Shift left, feeding the tap XOR into bit 0; reload the seed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequence engine: stores the tone sequence, replays it as timed tones,
// then grades the player's presses against the stored steps.
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned TONE_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_new_game,
  input  logic       i_start_round,
  input  logic       i_btn_valid,
  input  logic [3:0] i_btn,
  output logic [1:0] o_seq_out,
  output logic       o_tone_on,
  output logic       o_end_of_sequence,
  output logic       o_check_valid,
  output logic       o_correct_input,
  output logic       o_round_done,
  output logic [5:0] o_seq_len,
  output logic       o_busy
);

  localparam int unsigned CNT_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam int          IDX_W   = $clog2(MAX_LEN);

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [5:0]       LEN_MAX   = 6'(MAX_LEN);

  seq_state_t       r_state;
  logic [5:0]       r_len;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_chk;
  logic [CNT_W-1:0] r_cnt;
  tone_idx_t        r_mem [MAX_LEN];

  logic [1:0]       r_seq_out;
  logic             r_tone_on;
  logic             r_eos;
  logic             r_check_valid;
  logic             r_correct;
  logic             r_round_done;

  logic [15:0]      w_lfsr;
  logic             w_lfsr_unused;
  tone_idx_t        w_step;
  logic [5:0]       w_len_base;
  logic             w_append;
  logic [IDX_W-1:0] w_wr_idx;
  tone_idx_t        w_first;
  logic [IDX_W-1:0] w_last_idx;
  tone_idx_t        w_press_idx;
  logic             w_press_ok;

  simon_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (1'b1),
    .o_lfsr (w_lfsr)
  );

  // Only the low two bits pick a tone; the rest of the register is state only
  assign w_step        = w_lfsr[1:0];
  assign w_lfsr_unused = ^w_lfsr[15:2];

  // A new_game arriving with start_round clears first, so the append lands at 0
  assign w_len_base = i_new_game ? 6'd0 : r_len;
  assign w_append   = (r_state == S_IDLE) && i_start_round && (w_len_base < LEN_MAX);
  assign w_wr_idx   = w_len_base[IDX_W-1:0];
  // Step 0 is being written on this same edge when the sequence was empty
  assign w_first    = (w_len_base == 6'd0) ? w_step : r_mem[0];
  assign w_last_idx = IDX_W'(r_len - 6'd1);

  // Press is correct only if it round-trips through the tone table (one-hot)
  // and names the stored step
  assign w_press_idx = onehot_to_idx(i_btn);
  assign w_press_ok  = (i_btn == GAME_TONES[w_press_idx]) && (w_press_idx == r_mem[r_chk]);

  // Sequence memory: written on append only, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_append) begin
      r_mem[w_wr_idx] <= w_step;
    end
  end

  // Playback / listen FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_len         <= 6'd0;
      r_idx         <= '0;
      r_chk         <= '0;
      r_cnt         <= '0;
      r_seq_out     <= 2'd0;
      r_tone_on     <= 1'b0;
      r_eos         <= 1'b0;
      r_check_valid <= 1'b0;
      r_correct     <= 1'b0;
      r_round_done  <= 1'b0;
    end else begin
      r_eos         <= 1'b0;
      r_check_valid <= 1'b0;
      r_correct     <= 1'b0;
      r_round_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_round) begin
            r_len     <= w_append ? (w_len_base + 6'd1) : w_len_base;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_seq_out <= w_first;
            r_tone_on <= 1'b1;
            r_state   <= S_PLAY_ON;
          end else if (i_new_game) begin
            r_len <= 6'd0;
          end
        end
        S_PLAY_ON: begin
          if (r_cnt == TONE_LAST) begin
            r_cnt     <= '0;
            r_tone_on <= 1'b0;
            r_state   <= S_PLAY_GAP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PLAY_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (r_idx == w_last_idx) begin
              r_chk   <= '0;
              r_eos   <= 1'b1;
              r_state <= S_LISTEN;
            end else begin
              r_idx     <= r_idx + IDX_ONE;
              r_seq_out <= r_mem[r_idx + IDX_ONE];
              r_tone_on <= 1'b1;
              r_state   <= S_PLAY_ON;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_LISTEN: begin
          if (i_btn_valid) begin
            r_check_valid <= 1'b1;
            r_correct     <= w_press_ok;
            if (w_press_ok && (r_chk == w_last_idx)) begin
              r_round_done <= 1'b1;
              r_state      <= S_IDLE;
            end else if (w_press_ok) begin
              r_chk <= r_chk + IDX_ONE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_tone_on <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_seq_out         = r_seq_out;
  assign o_tone_on         = r_tone_on;
  assign o_end_of_sequence = r_eos;
  assign o_check_valid     = r_check_valid;
  assign o_correct_input   = r_correct;
  assign o_round_done      = r_round_done;
  assign o_seq_len         = r_len;
  assign o_busy            = (r_state != S_IDLE);

endmodule
